mac_acc_stage: RTL and testbench
================================

Name: mac_acc_stage

Overview:
- Downstream consumer of the multiply-add stage's DATA_OUT (A*B+C) result word.
- Accepts one result per valid/ready handshake and sums a block of N_SAMPLES results with saturation.
- Presents each block sum on a valid/ready output with a sticky saturation flag, for the next processing/readout stage.

Parameters:
- IN_W, outR (package constant, 16), width of incoming result word (unsigned).
- ACC_W, 24, width of accumulator and out_data; ACC_W >= IN_W required.
- N_SAMPLES, 8, results per block; power of two, 2..256.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (assert 0 -> immediate reset; release synchronous to clk in system).
- clr  input  1  synchronous block abort: discards partial sum and any held output.
- in_data  input  IN_W  result word from upstream multiply-add stage.
- in_valid  input  1  in_data valid.
- in_ready  output  1  stage can accept in_data this cycle.
- out_data  output  ACC_W  block sum (or average, see Optional Feature).
- out_valid  output  1  out_data/out_sat valid.
- out_ready  input  1  downstream accepts out_data.
- out_sat  output  1  saturation occurred in the held block.
- busy  output  1  at least one sample accumulated, or result held.

Behaviour:
- Reset (rst=0): state=ACCUM, acc=0, cnt=0, out_data=0, out_valid=0, out_sat=0, busy=0; in_ready=1 after release.
- States: ACCUM, HOLD (2-state FSM, enum in package).
- ACCUM: in_ready=1, out_valid=0. On in_valid&&in_ready: acc <= sat(acc+in_data), cnt <= cnt+1; sat flag set if sum > 2^ACC_W-1 (acc clamps to all-ones, stays clamped).
- Accept of sample number N_SAMPLES (cnt==N_SAMPLES-1): out_data <= final sum incl. this sample, out_sat <= sticky flag incl. this sample, out_valid=1 on next cycle; acc, cnt, flag cleared; state -> HOLD. Latency: 1 cycle from last accept to out_valid.
- HOLD: in_ready=0, out_valid=1, out_data/out_sat stable. On out_ready=1: out_valid=0 next cycle, state -> ACCUM; new samples accepted from that next cycle (no same-cycle pass-through; max throughput N_SAMPLES+1 cycles per block).
- in_valid while in_ready=0: ignored, no state change; upstream must hold data.
- clr=1 (any state): next cycle acc=0, cnt=0, flag=0, out_valid=0, out_sat=0, state=ACCUM; a sample presented in the clr cycle is dropped; clr overrides out_ready and in_valid.
- Input is zero-extended to ACC_W before adding; cnt width = $clog2(N_SAMPLES)+1, never wraps past N_SAMPLES-1 in ACCUM.
- Reset mid-block or mid-HOLD: all state lost, no output emitted.
- busy = (cnt!=0) || (state==HOLD).

Optional Feature:
- Macro MAC_ACC_AVG_EN.
- Defined: out_data = saturated block sum >> log2(N_SAMPLES) (floor average, upper bits zero); out_sat unchanged semantics.
- Undefined: out_data = saturated block sum. Handshake and timing identical in both builds.

Decomposition:
- Shared package (alongside the existing multiply-add parameter package): IN_W (=outR), default ACC_W, default N_SAMPLES, state enum typedef {ACCUM, HOLD}.
- One sub-module natural: sat_add (unsigned saturating adder, ACC_W wide, outputs sum and overflow bit), purely combinational, instantiated once.

Test Plan:
- Reset then 8 samples of 100, out_ready=1 -> out_valid one cycle after 8th accept, out_data=800, out_sat=0; (AVG_EN: out_data=100).
- Samples 1..8 with out_ready=0 for 5 cycles -> out_valid held, out_data=36 stable, in_ready=0, extra in_valid ignored; release -> next block accepted the following cycle.
- ACC_W=16, 8 samples of 0xFFFF -> out_data=0xFFFF, out_sat=1; next block of 8x1 -> out_data=8, out_sat=0.
- 3 samples of 50 then clr=1 with in_valid=1 -> busy=0 next cycle; following 8 samples of 10 -> out_data=80.
- Random in_valid gaps (50% duty) over 4 blocks of random data -> each out_data equals scoreboard sum; no sample lost or duplicated.
- rst=0 asserted mid-HOLD asynchronously (between edges) -> out_valid, out_data, out_sat, busy go to 0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/mac_acc_stage_pkg.sv
// ---------------------------------------------------------------------------
// mac_acc_stage_pkg
// Shared constants and types for the block accumulator that sits behind the
// multiply-add stage.
//   outR          : width of the multiply-add DATA_OUT word (mirrors the
//                   multiply-add parameter package)
//   IN_W          : incoming result width (= outR)
//   ACC_W_DEF     : default accumulator / out_data width
//   N_SAMPLES_DEF : default number of results per block
//   state_e       : accumulator FSM states {ACCUM, HOLD}
// Optional build macro used by the top: MAC_ACC_AVG_EN
// ---------------------------------------------------------------------------
package mac_acc_stage_pkg;

   localparam int outR          = 16;
   localparam int IN_W          = outR;
   localparam int ACC_W_DEF     = 24;
   localparam int N_SAMPLES_DEF = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage : mac_acc_stage_pkg

// File: rtl/mac_acc_stage_sat_add.sv
// ---------------------------------------------------------------------------
// mac_acc_stage_sat_add
// Purely combinational unsigned saturating adder.
//   a_i, b_i : W-bit unsigned operands
//   sum_o    : a_i + b_i, clamped to all-ones on overflow
//   ovf_o    : 1 when the true sum exceeds 2^W-1
// ---------------------------------------------------------------------------
module mac_acc_stage_sat_add #(
   parameter int W = 24
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   logic [W:0] full_sum;

   // One extra bit catches the carry out of the W-bit add.
   assign full_sum = {1'b0, a_i} + {1'b0, b_i};
   assign ovf_o    = full_sum[W];
   assign sum_o    = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule : mac_acc_stage_sat_add

// File: rtl/mac_acc_stage.sv
// ---------------------------------------------------------------------------
// mac_acc_stage
// Sums blocks of N_SAMPLES unsigned multiply-add results with saturation and
// presents each block sum on a valid/ready output with a sticky saturation
// flag.
// Build option: define MAC_ACC_AVG_EN to output the floor average
// (sum >> log2(N_SAMPLES)) instead of the raw saturated sum.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   clr         : synchronous block abort (drops partial sum and held result)
//   in_data     : IN_W-bit result word from the multiply-add stage
//   in_valid    : in_data valid
//   in_ready    : stage accepts in_data this cycle
//   out_data    : ACC_W-bit block sum (or average)
//   out_valid   : out_data/out_sat valid
//   out_ready   : downstream accepts out_data
//   out_sat     : saturation occurred in the held block
//   busy        : a sample has been accumulated, or a result is held
//   dbg_state_o : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds data stable while valid=1 and ready=0. Ready
// never depends on the partner's valid in the same cycle; clr overrides
// both handshakes (no transfer happens in a clr cycle).
// ---------------------------------------------------------------------------
module mac_acc_stage
   import mac_acc_stage_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int N_SAMPLES = N_SAMPLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sat,
   output logic             busy,
   output state_e           dbg_state_o
);

   localparam int CNT_W   = $clog2(N_SAMPLES) + 1;
   localparam int SHIFT_W = $clog2(N_SAMPLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

   state_e           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             flag_q;
   logic [ACC_W-1:0] out_data_q;
   logic             out_sat_q;

   logic [ACC_W-1:0] in_ext;
   logic [ACC_W-1:0] sum_d;
   logic             ovf;
   logic             flag_d;
   logic [ACC_W-1:0] out_data_d;
   logic             accept;

   assign in_ext = ACC_W'(in_data);

   mac_acc_stage_sat_add #(.W(ACC_W)) u_sat_add (
      .a_i   (acc_q),
      .b_i   (in_ext),
      .sum_o (sum_d),
      .ovf_o (ovf)
   );

   assign accept = in_valid && (state_q == ACCUM) && !clr;
   assign flag_d = flag_q | ovf;

`ifdef MAC_ACC_AVG_EN
   assign out_data_d = sum_d >> SHIFT_W;
`else
   assign out_data_d = sum_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ACCUM;
         acc_q      <= '0;
         cnt_q      <= '0;
         flag_q     <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else if (clr) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         flag_q    <= 1'b0;
         out_sat_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  if (cnt_q == LAST_CNT) begin
                     // Last sample of the block: capture result, restart sum.
                     out_data_q <= out_data_d;
                     out_sat_q  <= flag_d;
                     acc_q      <= '0;
                     cnt_q      <= '0;
                     flag_q     <= 1'b0;
                     state_q    <= HOLD;
                  end else begin
                     acc_q  <= sum_d;
                     cnt_q  <= cnt_q + 1'b1;
                     flag_q <= flag_d;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   // Handshake outputs decode straight from the state register.
   assign in_ready    = (state_q == ACCUM);
   assign out_valid   = (state_q == HOLD);
   assign out_data    = out_data_q;
   assign out_sat     = out_sat_q;
   assign busy        = (cnt_q != '0) || (state_q == HOLD);
   assign dbg_state_o = state_q;

endmodule : mac_acc_stage

// File: tb/tb_mac_acc_stage.sv
// ---------------------------------------------------------------------------
// tb_mac_acc_stage
// Two instances share one stimulus stream: dut (ACC_W=24) and dut16
// (ACC_W=16, to reach saturation). A reference model builds the expected
// block results as samples are accepted; monitors pop and compare them when
// each instance transfers a result.
// ---------------------------------------------------------------------------
module tb_mac_acc_stage;
   import mac_acc_stage_pkg::*;

   localparam int N = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            clr = 1'b0;
   logic [IN_W-1:0] in_data = '0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;

   logic            in_ready, out_valid, out_sat, busy;
   logic [23:0]     out_data;
   state_e          dbg_state;

   logic            in_ready16, out_valid16, out_sat16, busy16;
   logic [15:0]     out_data16;
   state_e          dbg_state16;

   mac_acc_stage #(.ACC_W(24), .N_SAMPLES(N)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sat(out_sat), .busy(busy), .dbg_state_o(dbg_state)
   );

   mac_acc_stage #(.ACC_W(16), .N_SAMPLES(N)) dut16 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready16),
      .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready),
      .out_sat(out_sat16), .busy(busy16), .dbg_state_o(dbg_state16)
   );

   // scoreboard
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [24:0] exp_q[$];    // {sat, data} for dut
   logic [16:0] exp16_q[$];  // {sat, data} for dut16

   longint m_acc24, m_acc16;
   bit     m_sat24, m_sat16;
   int     m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic longint exp_val(input longint s);
`ifdef MAC_ACC_AVG_EN
      return s >> $clog2(N);
`else
      return s;
`endif
   endfunction

   task automatic model_clear();
      m_acc24 = 0; m_acc16 = 0; m_sat24 = 0; m_sat16 = 0; m_cnt = 0;
   endtask

   task automatic model_push(input logic [IN_W-1:0] d);
      m_acc24 = m_acc24 + longint'(d);
      if (m_acc24 > 64'hFF_FFFF) begin m_acc24 = 64'hFF_FFFF; m_sat24 = 1; end
      m_acc16 = m_acc16 + longint'(d);
      if (m_acc16 > 64'hFFFF) begin m_acc16 = 64'hFFFF; m_sat16 = 1; end
      m_cnt++;
      if (m_cnt == N) begin
         exp_q.push_back({m_sat24, 24'(exp_val(m_acc24))});
         exp16_q.push_back({m_sat16, 16'(exp_val(m_acc16))});
         model_clear();
      end
   endtask

   // driver: present one sample, wait (bounded) for acceptance
   task automatic send(input logic [IN_W-1:0] d);
      bit done = 0;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         if (in_ready) done = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (done) model_push(d);
      else check_eq("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // monitors: compare on each output transfer
   always @(negedge clk) begin
      if (rst && !clr && out_valid && out_ready) begin
         if (exp_q.size() == 0) check_eq("unexpected_out", 32'(out_data), 32'hDEAD);
         else begin
            logic [24:0] e;
            e = exp_q.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e[23:0]));
            check_eq("out_sat", 32'(out_sat), 32'(e[24]));
         end
      end
      if (rst && !clr && out_valid16 && out_ready) begin
         if (exp16_q.size() == 0) check_eq("unexpected_out16", 32'(out_data16), 32'hDEAD);
         else begin
            logic [16:0] e;
            e = exp16_q.pop_front();
            check_eq("out_data16", 32'(out_data16), 32'(e[15:0]));
            check_eq("out_sat16", 32'(out_sat16), 32'(e[16]));
         end
      end
   end

   initial begin
      model_clear();
      // reset state
      #12;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_sat", 32'(out_sat), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      cyc(1);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      // 8 x 100, out_ready=1
      out_ready = 1'b1;
      for (int i = 0; i < N - 1; i++) send(16'd100);
      check_eq("t1_valid_before", 32'(out_valid), 32'd0);
      check_eq("t1_busy", 32'(busy), 32'd1);
      send(16'd100);
      check_eq("t1_latency_valid", 32'(out_valid), 32'd1);
      check_eq("t1_in_ready_hold", 32'(in_ready), 32'd0);
      check_eq("t1_data", 32'(out_data), 32'(exp_val(800)));
      cyc(1);
      check_eq("t1_valid_drop", 32'(out_valid), 32'd0);
      check_eq("t1_in_ready_back", 32'(in_ready), 32'd1);
      check_eq("t1_busy_idle", 32'(busy), 32'd0);

      // 1..8 with back-pressure, extra in_valid ignored
      out_ready = 1'b0;
      for (int i = 1; i <= N; i++) send(16'(i));
      in_data  = 16'd99;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_eq("t2_hold_valid", 32'(out_valid), 32'd1);
         check_eq("t2_hold_data", 32'(out_data), 32'(exp_val(36)));
         check_eq("t2_hold_in_ready", 32'(in_ready), 32'd0);
         check_eq("t2_hold_state", 32'(dbg_state), 32'(HOLD));
         cyc(1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc(1);
      check_eq("t2_release_valid", 32'(out_valid), 32'd0);
      check_eq("t2_release_ready", 32'(in_ready), 32'd1);
      check_eq("t2_release_busy", 32'(busy), 32'd0);

      // saturation on the 16-bit instance, then a clean block
      for (int i = 0; i < N; i++) send(16'hFFFF);
      check_eq("t3_sat16", 32'(out_sat16), 32'd1);
      check_eq("t3_data16", 32'(out_data16), 32'(exp_val(64'hFFFF)));
      for (int i = 0; i < N; i++) send(16'd1);
      check_eq("t3_clean_sat16", 32'(out_sat16), 32'd0);
      check_eq("t3_clean_data16", 32'(out_data16), 32'(exp_val(8)));

      // clr mid-block with a sample presented
      cyc(1);
      for (int i = 0; i < 3; i++) send(16'd50);
      check_eq("t4_busy_before", 32'(busy), 32'd1);
      clr      = 1'b1;
      in_data  = 16'd50;
      in_valid = 1'b1;
      cyc(1);
      clr      = 1'b0;
      in_valid = 1'b0;
      model_clear();
      check_eq("t4_busy_after", 32'(busy), 32'd0);
      check_eq("t4_busy16_after", 32'(busy16), 32'd0);
      for (int i = 0; i < N; i++) send(16'd10);
      check_eq("t4_data", 32'(out_data), 32'(exp_val(80)));

      // random data with random gaps, 4 blocks
      for (int i = 0; i < 4 * N; i++) begin
         cyc($urandom_range(0, 2));
         send(16'($urandom_range(0, 16'hFFFF)));
      end
      for (int i = 0; i < 50 && (exp_q.size() != 0 || exp16_q.size() != 0); i++) cyc(1);
      check_eq("drain_q", 32'(exp_q.size()), 32'd0);
      check_eq("drain_q16", 32'(exp16_q.size()), 32'd0);

      // asynchronous reset while holding a result
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) send(16'd7);
      check_eq("t6_in_hold", 32'(out_valid), 32'd1);
      #3 rst = 1'b0;
      #2;
      check_eq("t6_valid", 32'(out_valid), 32'd0);
      check_eq("t6_data", 32'(out_data), 32'd0);
      check_eq("t6_sat", 32'(out_sat), 32'd0);
      check_eq("t6_busy", 32'(busy), 32'd0);
      exp_q.delete();
      exp16_q.delete();
      model_clear();
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
      cyc(1);
      check_eq("t6_in_ready", 32'(in_ready), 32'd1);
      check_eq("t6_valid_after", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mac_acc_stage
